// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, lock-state encoding and saturating counter helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;
    localparam int CNT_W       = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1023);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } lock_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    // Clamp an (n+1)-bit length back into the n-bit output range.
    function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W:0] v);
        return v[CNT_W] ? CNT_MAX : v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge detector for one sync input, sampled on pix_en; SYNC_FILTER_EN adds a 2-sample glitch filter.
// Latency: rise is combinational in the sampling pix_en cycle (one pix_en later with SYNC_FILTER_EN).
// Backpressure: none; history only advances on pix_en.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_en,
    input  logic sync_in,
    output logic rise
);

`ifdef SYNC_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (pix_en) begin
            hist <= {hist[0], sync_in};
        end
    end

    // Filtered level is "high now and last sample"; its rise needs the sample before that low.
    assign rise = pix_en & sync_in & hist[0] & ~hist[1];
`else
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else if (pix_en) begin
            sync_q <= sync_in;
        end
    end

    assign rise = pix_en & sync_in & ~sync_q;
`endif

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel/line counters from HS/VS, measures line/frame lengths and tracks timing lock (SYNC_FILTER_EN optional).
// Latency: counters update the clk after the pix_en cycle that samples a sync rise; locked/err one clk after a VS verdict.
// Backpressure: none; all state advances only on pix_en and outputs hold between strobes.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_len,
    output logic             locked,
    output logic             err
);

    localparam logic [CNT_W:0] H_LEN  = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0] V_LEN  = (CNT_W+1)'(V_TOTAL);
    localparam logic [2:0]     LOCK_N = 3'(LOCK_FRAMES);

    logic              hs_rise;
    logic              vs_rise;
    lock_state_t       state;
    logic [2:0]        match_cnt;
    logic [2:0]        match_inc;
    logic              line_ok;
    logic              line_ok_nxt;
    logic              verdict;
    logic              sat_hit;
    logic              frame_bad;
    logic [CNT_W:0]    h_len;
    logic [CNT_W:0]    v_len;
    logic [CNT_W-1:0]  hcount_nxt;
    logic [CNT_W-1:0]  vcount_nxt;

    sync_edge_detect u_hs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .sync_in (hs_in),
        .rise    (hs_rise)
    );

    sync_edge_detect u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .sync_in (vs_in),
        .rise    (vs_rise)
    );

    assign h_len     = (CNT_W+1)'(hcount) + (CNT_W+1)'(1);
    assign v_len     = (CNT_W+1)'(vcount) + (CNT_W+1)'(1);
    assign match_inc = match_cnt + 3'd1;

    always_comb begin
        hcount_nxt  = hs_rise ? '0 : sat_inc(hcount);
        vcount_nxt  = vs_rise ? '0 : (hs_rise ? sat_inc(vcount) : vcount);
        line_ok_nxt = line_ok;
        // Lines seen before the reference VS are only measured, never judged.
        if (hs_rise && (state != SEARCH)) begin
            line_ok_nxt = line_ok & (h_len == H_LEN);
        end
        verdict   = line_ok_nxt & (v_len == V_LEN);
        sat_hit   = (hcount_nxt == CNT_MAX) || (vcount_nxt == CNT_MAX);
        frame_bad = sat_hit | (vs_rise & ~verdict);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount    <= '0;
            vcount    <= '0;
            line_len  <= '0;
            frame_len <= '0;
            line_ok   <= 1'b1;
        end else if (pix_en) begin
            hcount  <= hcount_nxt;
            vcount  <= vcount_nxt;
            line_ok <= vs_rise ? 1'b1 : line_ok_nxt;
            if (hs_rise) begin
                line_len <= sat_len(h_len);
            end
            if (vs_rise) begin
                frame_len <= sat_len(v_len);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            match_cnt <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (pix_en) begin
                case (state)
                    SEARCH: begin
                        if (vs_rise) begin
                            state     <= CHECK;
                            match_cnt <= '0;
                        end
                    end
                    CHECK: begin
                        if (frame_bad) begin
                            state <= SEARCH;
                        end else if (vs_rise) begin
                            match_cnt <= match_inc;
                            if (match_inc == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (frame_bad) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized bench for vga_sync_decoder against a line-list reference model, reduced raster for run time.
// Latency/backpressure: outputs checked every clk at the falling edge.
module tb_vga_sync_decoder;

    localparam int H_NOM  = 40;
    localparam int V_NOM  = 12;
    localparam int LOCK_N = 2;
    localparam int HS_W   = 6;
    localparam int VS_W   = 2;
    localparam int FRAME  = H_NOM * V_NOM;
    localparam int CMAX   = 1023;
`ifdef SYNC_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       pix_en;
    logic       hs_in;
    logic       vs_in;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] line_len;
    logic [9:0] frame_len;
    logic       locked;
    logic       err;

    vga_sync_decoder #(
        .H_TOTAL     (H_NOM),
        .V_TOTAL     (V_NOM),
        .LOCK_FRAMES (LOCK_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .hcount    (hcount),
        .vcount    (vcount),
        .line_len  (line_len),
        .frame_len (frame_len),
        .locked    (locked),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    // Reference model: pixels since last line start, lines since last frame start,
    // lengths of the lines of the frame being judged, and a run of good frames.
    int   m_pix, m_lines, m_llen, m_flen, m_run;
    logic m_armed, m_err;
    logic [1:0] hs_hist, vs_hist;
    int   frame_lines[$];

    // Raster generator and scenario knobs.
    int   g_h, g_v, g_len;
    logic short_next = 1'b0;
    logic sync_off   = 1'b0;
    int   glitch_pos = -1;
    int   pe_mode    = 0;

    int   tick_n = 0;
    int   err_seen = 0;
    int   vs_rises = 0;
    int   third_tick = -100;
    int   lock_tick = -1;
    logic vs_prev_gen = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [41:0] obs();
        return {hcount, vcount, line_len, frame_len, locked, err};
    endfunction

    function automatic logic [41:0] exp_vec();
        int hc, vc;
        hc = (m_pix > CMAX) ? CMAX : m_pix;
        vc = (m_lines > CMAX) ? CMAX : m_lines;
        return {10'(hc), 10'(vc), 10'(m_llen), 10'(m_flen),
                (m_armed && (m_run >= LOCK_N)), m_err};
    endfunction

    task automatic model_reset();
        m_pix = 0; m_lines = 0; m_llen = 0; m_flen = 0; m_run = 0;
        m_armed = 1'b0; m_err = 1'b0;
        hs_hist = 2'b00; vs_hist = 2'b00;
        frame_lines.delete();
    endtask

    task automatic model_step(input logic h, input logic v);
        logic hr, vr, good, sat;
        int   lp;
`ifdef SYNC_FILTER_EN
        hr = h && hs_hist[0] && !hs_hist[1];
        vr = v && vs_hist[0] && !vs_hist[1];
`else
        hr = h && !hs_hist[0];
        vr = v && !vs_hist[0];
`endif
        hs_hist = {hs_hist[0], h};
        vs_hist = {vs_hist[0], v};
        lp = (m_lines > CMAX) ? CMAX : m_lines;
        if (hr) begin
            if (m_armed) frame_lines.push_back(m_pix + 1);
            m_llen  = (m_pix + 1 > CMAX) ? CMAX : m_pix + 1;
            m_pix   = 0;
            m_lines = m_lines + 1;
        end else begin
            m_pix = m_pix + 1;
        end
        good = 1'b0;
        if (vr) begin
            good = (lp + 1 == V_NOM);
            foreach (frame_lines[i]) if (frame_lines[i] != H_NOM) good = 1'b0;
            m_flen  = (lp + 1 > CMAX) ? CMAX : lp + 1;
            m_lines = 0;
            frame_lines.delete();
        end
        sat = (m_pix >= CMAX) || (m_lines >= CMAX);
        if (!m_armed) begin
            if (vr) begin
                m_armed = 1'b1;
                m_run   = 0;
            end
        end else if (sat || (vr && !good)) begin
            if (m_run >= LOCK_N) m_err = 1'b1;
            m_armed = 1'b0;
            m_run   = 0;
        end else if (vr && (m_run < LOCK_N)) begin
            m_run = m_run + 1;
        end
    endtask

    task automatic gen_sample(output logic h, output logic v);
        h = !sync_off && (g_h < HS_W);
        v = !sync_off && (g_v < VS_W);
        if ((glitch_pos >= 0) && (g_h == glitch_pos)) begin
            h = 1'b1;
            glitch_pos = -1;
        end
        g_h = g_h + 1;
        if (g_h >= g_len) begin
            g_h = 0;
            g_v = (g_v + 1) % V_NOM;
            g_len = short_next ? H_NOM - 1 : H_NOM;
            short_next = 1'b0;
        end
    endtask

    task automatic tick();
        logic h, v;
        @(negedge clk);
        check_eq("outs", 64'(obs()), 64'(exp_vec()));
        if (err) err_seen++;
        if (locked && (lock_tick < 0)) lock_tick = tick_n;
        m_err = 1'b0;
        if (!rst_n) begin
            pix_en = 1'b0;
        end else begin
            case (pe_mode)
                0:       pix_en = 1'b1;
                1:       pix_en = ((tick_n % 4) == 0);
                default: pix_en = 1'($urandom_range(0, 1));
            endcase
        end
        if (pix_en) begin
            gen_sample(h, v);
            hs_in = h;
            vs_in = v;
            if (v && !vs_prev_gen) begin
                vs_rises++;
                if (vs_rises == 3) third_tick = tick_n;
            end
            vs_prev_gen = v;
            model_step(h, v);
        end
        tick_n++;
    endtask

    task automatic run_pix(input int n);
        int k = 0;
        for (int c = 0; (c < 16 * n + 16) && (k < n); c++) begin
            tick();
            if (pix_en) k++;
        end
    endtask

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        g_h   = $urandom_range(0, H_NOM - 1);
        g_v   = $urandom_range(VS_W + 1, V_NOM - 1);
        g_len = H_NOM;
        model_reset();
        tick();
        check_eq("reset_state", 64'(obs()), 64'(0));
        tick();
        rst_n = 1'b1;

        // Clean continuous stream: lock one clk after the 3rd VS rise.
        run_pix(4 * FRAME);
        check_eq("lock_latency", 64'(lock_tick), 64'(third_tick + 1 + FILT));
        check_eq("lock_a", 64'(locked), 64'(1));
        check_eq("err_a", 64'(err_seen), 64'(0));
        check_eq("line_len_a", 64'(line_len), 64'(H_NOM));
        check_eq("frame_len_a", 64'(frame_len), 64'(V_NOM));

        // One short line inside a locked frame, then relock.
        err_seen = 0;
        run_pix($urandom_range(40, 400));
        short_next = 1'b1;
        run_pix(6 * FRAME);
        check_eq("short_err", 64'(err_seen), 64'(1));
        check_eq("relock_b", 64'(locked), 64'(1));

        // Sync removed while locked: hcount saturates.
        err_seen = 0;
        sync_off = 1'b1;
        run_pix(1100);
        check_eq("sat_hcount", 64'(hcount), 64'(CMAX));
        check_eq("sat_err", 64'(err_seen), 64'(1));
        check_eq("sat_unlock", 64'(locked), 64'(0));
        sync_off = 1'b0;
        run_pix(4 * FRAME);
        check_eq("relock_c", 64'(locked), 64'(1));

        // Mid-frame async reset, then sparse pix_en.
        run_pix($urandom_range(100, 300));
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", 64'(obs()), 64'(0));
        model_reset();
        pe_mode = 1;
        tick();
        tick();
        rst_n = 1'b1;
        err_seen = 0;
        run_pix(5 * FRAME);
        check_eq("lock_d", 64'(locked), 64'(1));
        check_eq("line_len_d", 64'(line_len), 64'(H_NOM));
        check_eq("frame_len_d", 64'(frame_len), 64'(V_NOM));
        check_eq("err_d", 64'(err_seen), 64'(0));

        // Random strobes, single-sample HS glitch mid-line.
        pe_mode = 2;
        err_seen = 0;
        run_pix(300);
        glitch_pos = $urandom_range(HS_W + 2, H_NOM - 4);
        run_pix(2 * FRAME);
        check_eq("glitch_err", 64'(err_seen), 64'(1 - FILT));
        check_eq("glitch_lock", 64'(locked), 64'(FILT));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
